qlm_prod_accum: RTL and testbench

- Downstream stage of the 16x16 approximate-multiplier top; consumes its registered 32-bit unsigned products.
- Accumulates a frame of products into a saturating wide sum.
- Emits one result per frame, with product count and saturation flag, over a valid/ready handshake.
- Upstream producer supplies in_valid/in_last aligned to the cycle its product register is valid.

---
 rtl/qlm_prod_accum.sv | 95 +++++++++
 tb/tb_qlm_prod_accum.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qlm_prod_accum.sv
// Frame accumulator behind the 16x16 approximate multiplier: sums a frame of
// 32-bit products into a saturating ACC_W-bit total and hands it off over valid/ready.
module qlm_prod_accum #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_sat
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  logic             accept;
  logic [ACC_W:0]   sum_wide;
  logic             ovf;
  logic [ACC_W-1:0] sum_n;
  logic [CNT_W-1:0] cnt_n;
  logic             sat_n;

  // A pending result blocks input only while downstream is stalling; once it
  // drains this cycle the slot is free, which gives back-to-back frames.
  assign in_ready = (state == ACCUM) ? 1'b1 : out_ready;
  assign accept   = in_valid & in_ready;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    sum_wide = {1'b0, acc} + {{(ACC_W + 1 - 32){1'b0}}, in_prod};
    ovf      = sum_wide[ACC_W];
    sum_n    = ovf ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    cnt_n    = (&cnt) ? cnt : cnt + CNT_W'(1);
    sat_n    = sat | ovf;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      // Abort drops the frame and any pending result; out_* keep their values.
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (state == HOLD && out_ready) begin
        state     <= ACCUM;
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (in_last) begin
          // Later assignment wins, so a last beat during hand-off reloads HOLD.
          out_sum   <= sum_n;
          out_cnt   <= cnt_n;
          out_sat   <= sat_n;
          out_valid <= 1'b1;
          state     <= HOLD;
          acc       <= '0;
          cnt       <= '0;
          sat       <= 1'b0;
        end else begin
          acc <= sum_n;
          cnt <= cnt_n;
          sat <= sat_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_qlm_prod_accum.sv
// Self-checking bench: two instances (wide default, and ACC_W=33/CNT_W=2) share
// stimulus and are compared each cycle against a frame-level reference model.
module tb_qlm_prod_accum;

  localparam int ACC_A = 40;
  localparam int CNT_A = 16;
  localparam int ACC_B = 33;
  localparam int CNT_B = 2;

  localparam longint SMAX_A = (longint'(1) << ACC_A) - 1;
  localparam longint SMAX_B = (longint'(1) << ACC_B) - 1;
  localparam int     CMAX_A = (1 << CNT_A) - 1;
  localparam int     CMAX_B = (1 << CNT_B) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic [31:0]       in_prod;
  logic              in_last;
  logic              out_ready;

  logic              a_in_ready, a_out_valid, a_out_sat;
  logic [ACC_A-1:0]  a_out_sum;
  logic [CNT_A-1:0]  a_out_cnt;
  logic              b_in_ready, b_out_valid, b_out_sat;
  logic [ACC_B-1:0]  b_out_sum;
  logic [CNT_B-1:0]  b_out_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qlm_prod_accum #(.ACC_W(ACC_A), .CNT_W(CNT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sum(a_out_sum), .out_cnt(a_out_cnt), .out_sat(a_out_sat)
  );

  qlm_prod_accum #(.ACC_W(ACC_B), .CNT_W(CNT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum(b_out_sum), .out_cnt(b_out_cnt), .out_sat(b_out_sat)
  );

  // Reference: frame sum kept as a plain integer, clamped at the ceiling;
  // product count kept unbounded and clipped only when reported.
  typedef struct {
    bit     pend;
    longint osum;
    int     ocnt;
    bit     osat;
    longint fsum;
    int     fn;
    bit     fsat;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset();
    model_t m;
    m.pend = 0; m.osum = 0; m.ocnt = 0; m.osat = 0;
    m.fsum = 0; m.fn = 0; m.fsat = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, longint smax, int cmax, bit clr,
                                        bit vld, bit rdy, logic [31:0] prod, bit last);
    bit take;
    take = vld && (!m.pend || rdy);
    if (clr) begin
      m.fsum = 0; m.fn = 0; m.fsat = 0; m.pend = 0;
      return m;
    end
    if (m.pend && rdy) m.pend = 0;
    if (take) begin
      m.fsum = m.fsum + longint'(prod);
      m.fn   = m.fn + 1;
      if (m.fsum > smax) begin
        m.fsum = smax;
        m.fsat = 1;
      end
      if (last) begin
        m.osum = m.fsum;
        m.ocnt = (m.fn > cmax) ? cmax : m.fn;
        m.osat = m.fsat;
        m.pend = 1;
        m.fsum = 0; m.fn = 0; m.fsat = 0;
      end
    end
    return m;
  endfunction

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("a_out_valid", longint'(a_out_valid), longint'(ma.pend));
    check("a_out_sum",   longint'(a_out_sum),   ma.osum);
    check("a_out_cnt",   longint'(a_out_cnt),   longint'(ma.ocnt));
    check("a_out_sat",   longint'(a_out_sat),   longint'(ma.osat));
    check("b_out_valid", longint'(b_out_valid), longint'(mb.pend));
    check("b_out_sum",   longint'(b_out_sum),   mb.osum);
    check("b_out_cnt",   longint'(b_out_cnt),   longint'(mb.ocnt));
    check("b_out_sat",   longint'(b_out_sat),   longint'(mb.osat));
  endtask

  // One clock: drive at the falling edge, check in_ready before the rising
  // edge, advance the model, then check registered outputs just after it.
  task automatic cycle(input bit clr, input bit vld, input logic [31:0] prod,
                       input bit last, input bit rdy);
    @(negedge clk);
    clear = clr; in_valid = vld; in_prod = prod; in_last = last; out_ready = rdy;
    #1;
    check("a_in_ready", longint'(a_in_ready), longint'(!ma.pend || rdy));
    check("b_in_ready", longint'(b_in_ready), longint'(!mb.pend || rdy));
    ma = model_step(ma, SMAX_A, CMAX_A, clr, vld, rdy, prod, last);
    mb = model_step(mb, SMAX_B, CMAX_B, clr, vld, rdy, prod, last);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    cycle(0, 0, 32'h0, 0, 1);
  endtask

  initial begin
    logic [31:0] p;
    rst_n = 1'b0; clear = 0; in_valid = 0; in_prod = '0; in_last = 0; out_ready = 0;
    ma = model_reset();
    mb = model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", longint'(a_in_ready), 1);

    // Three-beat frame; result one cycle after the last beat, then drains.
    cycle(0, 1, 32'h1, 0, 1);
    cycle(0, 1, 32'h2, 0, 1);
    cycle(0, 1, 32'h3, 1, 1);
    check("tp1_sum", longint'(a_out_sum), 6);
    check("tp1_cnt", longint'(a_out_cnt), 3);
    idle();
    check("tp1_drop", longint'(a_out_valid), 0);

    // Back-to-back single-beat frames.
    cycle(0, 1, 32'hFFFF_FFFF, 1, 1);
    check("tp2_sum0", longint'(a_out_sum), 64'hFFFF_FFFF);
    cycle(0, 1, 32'h0000_0010, 1, 1);
    check("tp2_sum1", longint'(a_out_sum), 64'h10);
    check("tp2_cnt1", longint'(a_out_cnt), 1);
    check("tp2_vld1", longint'(a_out_valid), 1);
    idle();

    // Backpressure: result 12 held while the next beat waits.
    cycle(0, 1, 32'd5, 0, 1);
    cycle(0, 1, 32'd7, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 32'd9, 0, 0);
      check("tp3_hold_sum", longint'(a_out_sum), 12);
      check("tp3_hold_rdy", longint'(a_in_ready), 0);
    end
    cycle(0, 1, 32'd9, 0, 1);
    cycle(0, 1, 32'd1, 1, 1);
    check("tp3_next_sum", longint'(a_out_sum), 10);
    check("tp3_next_cnt", longint'(a_out_cnt), 2);
    idle();

    // Sum saturation on the 33-bit instance.
    cycle(0, 1, 32'hFFFF_FFFF, 0, 1);
    cycle(0, 1, 32'hFFFF_FFFF, 0, 1);
    cycle(0, 1, 32'h2, 1, 1);
    check("tp4_b_sum", longint'(b_out_sum), 64'h1_FFFF_FFFF);
    check("tp4_b_sat", longint'(b_out_sat), 1);
    check("tp4_b_cnt", longint'(b_out_cnt), 3);
    check("tp4_a_sum", longint'(a_out_sum), 64'h2_0000_0000);
    cycle(0, 1, 32'h1, 1, 1);
    check("tp4_b_sat_clr", longint'(b_out_sat), 0);
    check("tp4_b_sum1", longint'(b_out_sum), 1);
    idle();

    // Count saturation on the 2-bit counter.
    for (int i = 0; i < 4; i++) cycle(0, 1, 32'h1, 0, 1);
    cycle(0, 1, 32'h1, 1, 1);
    check("tp5_b_cnt", longint'(b_out_cnt), 3);
    check("tp5_b_sum", longint'(b_out_sum), 5);
    check("tp5_a_cnt", longint'(a_out_cnt), 5);
    idle();

    // Abort mid-frame; the beat presented with clear is dropped.
    cycle(0, 1, 32'h1, 0, 1);
    cycle(0, 1, 32'h1, 0, 1);
    cycle(1, 1, 32'd100, 0, 1);
    cycle(0, 1, 32'h4, 1, 1);
    check("tp6_sum", longint'(a_out_sum), 4);
    check("tp6_cnt", longint'(a_out_cnt), 1);
    cycle(0, 0, 32'h0, 0, 0);

    // Randomized traffic with bias towards large products to reach saturation.
    for (int i = 0; i < 2000; i++) begin
      p = ($urandom_range(0, 1) == 1) ? {16'hFFFF, 16'($urandom)} : $urandom;
      cycle(($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 7), p,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7));
    end

    // Asynchronous reset mid-frame with a result on the outputs.
    cycle(0, 1, 32'h33, 1, 0);
    cycle(0, 1, 32'h8, 0, 1);
    @(negedge clk);
    clear = 0; in_valid = 0; in_last = 0; out_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_a_valid", longint'(a_out_valid), 0);
    check("arst_a_sum",   longint'(a_out_sum),   0);
    check("arst_b_sum",   longint'(b_out_sum),   0);
    ma = model_reset();
    mb = model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs();
    cycle(0, 1, 32'h7, 1, 1);
    check("arst_after_sum", longint'(a_out_sum), 7);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
